// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller. Sequences post-reset fetch
//               suppression, load-use stalls, taken-branch flushes and
//               data-memory wait holds with a timeout that halts the core.
//               Also keeps a saturating count of fetch-stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int BOOT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count
);

    localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_t;

    state_t              cur_state;
    state_t              nxt_state;
    logic [BOOT_W-1:0]   boot_cnt;
    logic [BOOT_W-1:0]   boot_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_nxt;
    logic                load_use;
    logic                stall_inc;

    // A load in EX whose destination feeds the ID instruction; r0 never hazards.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    assign state  = cur_state;
    assign halted = (cur_state == HALT);

    // Fetch stalls are only counted while the pipeline is live.
    assign stall_inc = ((cur_state == RUN) || (cur_state == MEM_WAIT)) && !pc_write;

    // State and counter registers; reset acts without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= BOOT;
            boot_cnt  <= '0;
            wait_cnt  <= '0;
        end else begin
            cur_state <= nxt_state;
            boot_cnt  <= boot_nxt;
            wait_cnt  <= wait_nxt;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall_inc && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    // Next-state and same-cycle pipeline control decode.
    always_comb begin
        nxt_state   = cur_state;
        boot_nxt    = boot_cnt;
        wait_nxt    = wait_cnt;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;

        case (cur_state)
            BOOT: begin
                // Keep flushing IF/ID until the front end has settled.
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (boot_cnt == BOOT_W'(BOOT_CYCLES - 1)) begin
                    nxt_state = RUN;
                    boot_nxt  = '0;
                end else begin
                    boot_nxt = boot_cnt + 1'b1;
                end
            end

            RUN, MEM_WAIT: begin
                if (mem_busy) begin
                    // Freeze everything behind the memory stage.
                    pipe_hold = 1'b1;
                    if (cur_state == RUN) begin
                        nxt_state = MEM_WAIT;
                        wait_nxt  = WAIT_W'(1);
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                            nxt_state = HALT;
                        end
                    end
                end else begin
                    nxt_state = RUN;
                    wait_nxt  = '0;
                    if (ex_branch_taken) begin
                        // Redirect wins over load-use: the dependent instruction is squashed.
                        pc_write    = 1'b1;
                        ifid_write  = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        idex_bubble = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                    end
                end
            end

            HALT: begin
                pipe_hold = 1'b1;
            end

            default: begin
                nxt_state = BOOT;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Two instances share the
//               stimulus: one with default parameters and one with a 2-bit
//               stall counter. A cycle-level reference model predicts every
//               output from the documented control rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int BOOT_CYCLES = 4;
    localparam int MEM_TIMEOUT = 64;
    localparam int CNT_W       = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rt, ex_mem_read, ex_branch_taken, mem_busy;

    logic        pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, halted;
    logic [1:0]  state;
    logic [CNT_W-1:0] stall_count;

    logic        pc_write2, ifid_write2, ifid_flush2, idex_bubble2, pipe_hold2, halted2;
    logic [1:0]  state2;
    logic [1:0]  stall_count2;

    int checks = 0;
    int errors = 0;

    // Reference model: boot cycles left, consecutive busy cycles seen, halt flag.
    bit m_in_reset;
    int m_boot_left;
    int m_busy_run;
    bit m_halted;
    int m_stall;
    int m_stall2;

    bit e_pc, e_ifw, e_flush, e_bub, e_hold, e_halted;
    int e_state;

    hazard_ctrl #(
        .BOOT_CYCLES(BOOT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_hold(pipe_hold), .halted(halted),
        .state(state), .stall_count(stall_count)
    );

    hazard_ctrl #(
        .BOOT_CYCLES(BOOT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(2)
    ) dut2 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write2), .ifid_write(ifid_write2), .ifid_flush(ifid_flush2),
        .idex_bubble(idex_bubble2), .pipe_hold(pipe_hold2), .halted(halted2),
        .state(state2), .stall_count(stall_count2)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_reset  = 1'b1;
        m_boot_left = BOOT_CYCLES;
        m_busy_run  = 0;
        m_halted    = 1'b0;
        m_stall     = 0;
        m_stall2    = 0;
    endtask

    // Predict this cycle's outputs from the control rules.
    task automatic model_predict();
        bit lu;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        e_halted = m_halted && !m_in_reset;
        if (m_in_reset || m_boot_left > 0) e_state = 0;
        else if (m_halted)                 e_state = 3;
        else if (m_busy_run > 0)           e_state = 2;
        else                               e_state = 1;
        if (e_state == 0)                 {e_pc, e_ifw, e_flush, e_bub, e_hold} = 5'b01110;
        else if (e_state == 3 || mem_busy) {e_pc, e_ifw, e_flush, e_bub, e_hold} = 5'b00001;
        else if (ex_branch_taken)         {e_pc, e_ifw, e_flush, e_bub, e_hold} = 5'b11110;
        else if (lu)                      {e_pc, e_ifw, e_flush, e_bub, e_hold} = 5'b00010;
        else                              {e_pc, e_ifw, e_flush, e_bub, e_hold} = 5'b11000;
    endtask

    // Move the model across one rising edge.
    task automatic model_advance();
        if (m_in_reset) return;
        if (m_boot_left > 0) begin
            m_boot_left--;
        end else if (!m_halted) begin
            if (!e_pc) begin
                m_stall  = (m_stall < (1 << CNT_W) - 1) ? m_stall + 1 : m_stall;
                m_stall2 = (m_stall2 < 3) ? m_stall2 + 1 : m_stall2;
            end
            if (mem_busy) begin
                m_busy_run++;
                if (m_busy_run == MEM_TIMEOUT) m_halted = 1'b1;
            end else begin
                m_busy_run = 0;
            end
        end
    endtask

    task automatic check_all();
        model_predict();
        check1("pc_write",     32'(pc_write),     32'(e_pc));
        check1("ifid_write",   32'(ifid_write),   32'(e_ifw));
        check1("ifid_flush",   32'(ifid_flush),   32'(e_flush));
        check1("idex_bubble",  32'(idex_bubble),  32'(e_bub));
        check1("pipe_hold",    32'(pipe_hold),    32'(e_hold));
        check1("halted",       32'(halted),       32'(e_halted));
        check1("state",        32'(state),        32'(e_state));
        check1("stall_count",  32'(stall_count),  32'(m_stall));
        check1("state_w2",     32'(state2),       32'(e_state));
        check1("pc_write_w2",  32'(pc_write2),    32'(e_pc));
        check1("stall_count_w2", 32'(stall_count2), 32'(m_stall2));
    endtask

    // Called just after a rising edge: drive inputs, check mid-cycle, advance.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic mr, input logic [4:0] rd, input logic br,
                        input logic mb);
        id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br; mem_busy = mb;
        #3;
        check_all();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Assert reset away from any edge and check it acts at once, then release.
    task automatic async_reset_pulse();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
        m_in_reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        id_rs = 0; id_rt = 0; ex_rd = 0;
        id_uses_rt = 0; ex_mem_read = 0; ex_branch_taken = 0; mem_busy = 0;
        model_reset();

        // Reset state, before and after an edge.
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();

        // Boot sequence with quiet inputs, then normal flow.
        reset = 1'b0;
        m_in_reset = 1'b0;
        idle(BOOT_CYCLES + 2);

        // Load-use on rs, then rd=0 (no hazard), rt with and without id_uses_rt.
        step(5, 0, 0, 1, 5, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(1, 7, 1, 1, 7, 0, 0);
        step(1, 7, 0, 1, 7, 0, 0);
        step(5, 0, 0, 0, 5, 0, 0);

        // Taken branch with a load-use pending: branch wins.
        step(5, 0, 0, 1, 5, 1, 0);
        idle(1);

        // Three busy cycles then normal; busy exit into a branch and a load-use.
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(3, 0, 0, 1, 3, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(3, 0, 0, 1, 3, 0, 0);

        // Randomized traffic with short busy bursts.
        for (int i = 0; i < 300; i++) begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                 1'($urandom), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0));
        end

        // Reset in the middle of a memory wait.
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        async_reset_pulse();
        idle(BOOT_CYCLES + 1);

        // Busy one short of the timeout must not halt.
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) step(0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // Busy for exactly the timeout halts; halt persists with inputs low.
        for (int i = 0; i < MEM_TIMEOUT; i++) step(0, 0, 0, 0, 0, 0, 1);
        idle(3);
        step(5, 0, 0, 1, 5, 1, 0);
        async_reset_pulse();
        idle(BOOT_CYCLES);

        // Sustained load-use: the 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) step(9, 0, 0, 1, 9, 0, 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
